// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store controller for data_mem; misaligned half/word accesses
// are split into byte beats and load bytes are reassembled little-endian.
module lsu_mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic              mem_se,
  output logic [3:0]        mem_bs,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic we_q, uns_q, split_q, err_q, mis, last;
  logic [1:0] size_q, k, last_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, asm_q, ext;
  assign mis = (req_size == 2'd1 && req_addr[0]) || (req_size == 2'd2 && req_addr[1:0] != 2'b00);
  assign last = k == last_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      split_q <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'd0;
      last_q  <= 2'd0;
      k       <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      asm_q   <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && req_valid) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        split_q <= mis;
        last_q  <= mis ? (req_size == 2'd2 ? 2'd3 : 2'd1) : 2'd0;
        err_q   <= req_size == 2'd3;
        k       <= 2'd0;
      end
      if (state == ISSUE && we_q && !last)
        k <= k + 2'd1;
      if (state == WAIT) begin
        if (split_q)
          asm_q[{k, 3'b000} +: 8] <= mem_rdata[7:0];
        else
          asm_q <= mem_rdata;
        if (!last)
          k <= k + 2'd1;
      end
    end
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = !req_valid ? IDLE : req_size == 2'd3 ? RESP : ISSUE;
      ISSUE:   state_n = !we_q ? WAIT : last ? RESP : ISSUE;
      WAIT:    state_n = last ? RESP : ISSUE;
      default: state_n = IDLE;
    endcase
  end
  // Split half loads need explicit extension; split words already fill all 32 bits.
  assign ext = (split_q && size_q == 2'd1) ? {{16{asm_q[15] & ~uns_q}}, asm_q[15:0]} : asm_q;
  assign req_ready  = state == IDLE;
  assign mem_en     = state == ISSUE;
  assign mem_we     = mem_en & we_q;
  assign mem_se     = mem_en & ~split_q & ~uns_q;
  assign mem_bs     = !mem_en ? 4'h0 : split_q ? 4'h1 : size_q == 2'd2 ? 4'h3 : size_q == 2'd1 ? 4'h2 : 4'h1;
  assign mem_addr   = mem_en ? addr_q + ADDR_W'(k) : '0;
  assign mem_wdata  = !mem_en ? '0 : split_q ? {24'h0, wdata_q[{k, 3'b000} +: 8]} : wdata_q;
  assign resp_valid = state == RESP;
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = (resp_valid && !we_q && !err_q) ? ext : '0;
endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store controller directly upstream of data_mem. Accepts one memory request per handshake from the execute stage and drives the data_mem port (mem_en, mem_we, mem_se, mem_bs, addr, data_in).
- Aligned accesses are issued as a single data_mem access. Misaligned halfword/word accesses are split into sequential byte accesses, and the load result is reassembled little-endian.
- Returns one response per request to the writeback stage.

Parameters:
- ADDR_W, 32, address width; byte addresses wrap modulo 2^ADDR_W.
- DATA_W, 32, data width; fixed at 32, other values unsupported.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller accepts a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_unsigned  in  1  1 = zero-extend load result, 0 = sign-extend
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned
- mem_en  out  1  to data_mem mem_en
- mem_we  out  1  to data_mem mem_we
- mem_se  out  1  to data_mem mem_se
- mem_bs  out  4  to data_mem mem_bs: 4'h3 word, 4'h2 half, 4'h1 byte
- mem_addr  out  ADDR_W  to data_mem addr
- mem_wdata  out  32  to data_mem data_in
- mem_rdata  in  32  from data_mem data_out; valid the cycle after a load issue
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  load result; 0 for stores
- resp_err  out  1  illegal size flag, qualified by resp_valid

Behaviour:
- Reset values: state IDLE; all outputs 0 except req_ready = 1; assembly register and beat counter 0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready, latch the request and compute the beat count.
  - Aligned (byte; half with addr[0] = 0; word with addr[1:0] = 0): 1 beat.
  - Misaligned half: 2 beats. Misaligned word: 4 beats.
  - req_size = 3: go directly to RESP with resp_err = 1 and no memory access.
  - Otherwise go to ISSUE.
- req_ready is 0 in every state other than IDLE. No request queuing.
- ISSUE (beat k):
  - mem_en = 1, mem_we = req_we.
  - Aligned beat: mem_addr = req_addr, mem_bs per size, mem_se = ~req_unsigned, mem_wdata = req_wdata.
  - Split beat: mem_addr = req_addr + k (wrapping), mem_bs = 4'h1, mem_se = 0, mem_wdata[7:0] = req_wdata[8k+7:8k], upper bits 0.
  - Store: memory writes on the following edge. If last beat, go to RESP; else k+1 and stay in ISSUE.
  - Load: go to WAIT.
- WAIT:
  - mem_en = 0.
  - Aligned beat: capture mem_rdata whole.
  - Split beat: capture mem_rdata[7:0] into assembly byte k.
  - If last beat, go to RESP; else k+1 and go to ISSUE.
- RESP:
  - resp_valid = 1 for exactly one cycle, then IDLE.
  - Split loads: sign-extend the assembled data from bit 15 (half) or bit 31 (word) unless req_unsigned. Aligned loads use data_mem's own extension.
- mem_en = 0 in IDLE, WAIT and RESP.
- Latency from accept edge to resp_valid cycle:
  - Aligned store: 2 cycles.
  - Aligned load: 3 cycles.
  - Misaligned half store / load: 3 / 5 cycles.
  - Misaligned word store / load: 5 / 9 cycles.
  - Illegal size: 1 cycle.
- A request may be accepted in the IDLE cycle immediately following RESP; back-to-back requests therefore have no extra bubble.
- Reset asserted mid-operation:
  - Immediately return to IDLE and deassert mem_en and resp_valid.
  - Bytes of a split store already written remain in memory. No response is produced for the aborted request.
- Address wrap: a word at 0xFFFFFFFE accesses 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001.

Test Plan:
- Aligned word store 0xDEADBEEF @0x80000000, then word load @0x80000000 -> one mem_en cycle each; resp_valid 2 and 3 cycles after accept; resp_rdata = 0xDEADBEEF, resp_err = 0.
- Misaligned word store 0x11223344 @0x80000001 -> four byte writes at 0x80000001..0x80000004 with data 0x44, 0x33, 0x22, 0x11. Aligned word load @0x80000000 then returns 0x223344xx (xx = byte previously at 0x80000000).
- Misaligned half store 0x80F0 @0x80000011, then half load, signed -> 0xFFFF80F0; same load unsigned -> 0x000080F0; 5-cycle load latency.
- req_size = 3, req_addr = 0x80000000 -> no mem_en; resp_valid one cycle after accept with resp_err = 1.
- Assert rst during beat 2 of a misaligned word store @0x80000021 -> mem_en drops immediately; req_ready = 1 after release; bytes at 0x80000021/0x80000022 hold the new data, 0x80000023/0x80000024 unchanged.
- Misaligned word load at 0xFFFFFFFE -> beat addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001; req_valid held high across the response -> next accept in the cycle after RESP; req_ready = 0 throughout the busy period.
